// File: rtl/nested_radicals_pkg.sv
// Shared types and width helpers for the nested radical evaluator.
package nested_radicals_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQRT = 2'd1,
      NEXT = 2'd2
   } state_t;

   // One guard bit absorbs the inner root added to a full-scale term.
   function automatic int unsigned calc_sum_w(input int unsigned width);
      return width + 1;
   endfunction

   function automatic int unsigned calc_root_w(input int unsigned width);
      return (calc_sum_w(width) + 1) / 2;
   endfunction

endpackage

// File: rtl/nested_radicals_n_isqrt_step.sv
// One restoring square-root step: keep the trial bit if its square still fits.
module isqrt_step #(
   parameter int unsigned ROOT_W = 9,
   parameter int unsigned SUM_W  = 17
) (
   input  logic [SUM_W-1:0]  x,
   input  logic [ROOT_W-1:0] root,
   input  logic [ROOT_W-1:0] trial_bit,
   output logic [ROOT_W-1:0] next_root
);

   logic [ROOT_W-1:0]   cand;
   logic [2*ROOT_W-1:0] cand_sq;
   logic [2*ROOT_W-1:0] x_ext;

   always_comb begin
      cand      = root | trial_bit;
      cand_sq   = (2*ROOT_W)'(cand) * (2*ROOT_W)'(cand);
      x_ext     = (2*ROOT_W)'(x);
      next_root = (cand_sq <= x_ext) ? cand : root;
   end

endmodule

// File: rtl/nested_radicals_n.sv
// Iterative evaluator of isqrt(t0 + isqrt(t1 + ... + isqrt(t[d-1]))), one root bit per cycle.
module nested_radicals_n
   import nested_radicals_pkg::*;
#(
   parameter  int unsigned WIDTH  = 16,
   parameter  int unsigned DEPTH  = 3,
   localparam int unsigned SUM_W  = calc_sum_w(WIDTH),
   localparam int unsigned ROOT_W = calc_root_w(WIDTH),
   localparam int unsigned DSEL_W = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [DSEL_W-1:0]      depth,
   input  logic [DEPTH*WIDTH-1:0] terms,
   output logic                   busy,
   output logic                   done,
   output logic [ROOT_W-1:0]      y
);

   localparam logic [ROOT_W-1:0] MSB = ROOT_W'(1) << (ROOT_W - 1);

   state_t              state, state_n;
   logic [SUM_W-1:0]    x_reg, x_n;
   logic [ROOT_W-1:0]   root, root_n;
   logic [ROOT_W-1:0]   bit_r, bit_n;
   logic [DSEL_W-1:0]   stage, stage_n;
   logic [ROOT_W-1:0]   y_n;
   logic                done_n;
   logic [WIDTH-1:0]    term_q [DEPTH];
   logic [WIDTH-1:0]    term_n [DEPTH];

   logic [DSEL_W-1:0]   d_eff;
   logic [WIDTH-1:0]    first_term;
   logic [WIDTH-1:0]    inner_term;
   logic [ROOT_W-1:0]   step_root;

   isqrt_step #(
      .ROOT_W (ROOT_W),
      .SUM_W  (SUM_W)
   ) u_step (
      .x         (x_reg),
      .root      (root),
      .trial_bit (bit_r),
      .next_root (step_root)
   );

   // Clamp the requested depth and pick the innermost term straight from the inputs.
   always_comb begin
      if (depth == '0)
         d_eff = DSEL_W'(1);
      else if (depth > DSEL_W'(DEPTH))
         d_eff = DSEL_W'(DEPTH);
      else
         d_eff = depth;
      first_term = '0;
      inner_term = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (DSEL_W'(i) == d_eff - DSEL_W'(1))
            first_term = terms[i*WIDTH +: WIDTH];
         if (DSEL_W'(i) == stage - DSEL_W'(1))
            inner_term = term_q[i];
      end
   end

   always_comb begin
      state_n = state;
      x_n     = x_reg;
      root_n  = root;
      bit_n   = bit_r;
      stage_n = stage;
      y_n     = y;
      done_n  = 1'b0;
      term_n  = term_q;
      case (state)
         IDLE: begin
            if (start) begin
               for (int unsigned i = 0; i < DEPTH; i++)
                  term_n[i] = terms[i*WIDTH +: WIDTH];
               x_n     = SUM_W'(first_term);
               root_n  = '0;
               bit_n   = MSB;
               stage_n = d_eff - DSEL_W'(1);
               state_n = SQRT;
            end
         end
         SQRT: begin
            root_n = step_root;
            bit_n  = bit_r >> 1;
            if (bit_r[0])
               state_n = NEXT;
         end
         NEXT: begin
            if (stage != '0) begin
               x_n     = SUM_W'(root) + SUM_W'(inner_term);
               stage_n = stage - DSEL_W'(1);
               root_n  = '0;
               bit_n   = MSB;
               state_n = SQRT;
            end else begin
               y_n     = root;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         x_reg <= '0;
         root  <= '0;
         bit_r <= '0;
         stage <= '0;
         y     <= '0;
         done  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++)
            term_q[i] <= '0;
      end else begin
         state  <= state_n;
         x_reg  <= x_n;
         root   <= root_n;
         bit_r  <= bit_n;
         stage  <= stage_n;
         y      <= y_n;
         done   <= done_n;
         term_q <= term_n;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_nested_radicals_n.sv
// Directed bench for nested_radicals_n: default instance plus a DEPTH=2 instance for clamping.
module tb_nested_radicals_n;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  depth = '0;
   logic [47:0] terms = '0;
   logic        busy, done;
   logic [8:0]  y;

   logic        start2 = 1'b0;
   logic [1:0]  depth2 = '0;
   logic [31:0] terms2 = '0;
   logic        busy2, done2;
   logic [8:0]  y2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int e0    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   nested_radicals_n dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .depth (depth),
      .terms (terms),
      .busy  (busy),
      .done  (done),
      .y     (y)
   );

   nested_radicals_n #(.WIDTH(16), .DEPTH(2)) dut2 (
      .clk   (clk),
      .rst   (rst),
      .start (start2),
      .depth (depth2),
      .terms (terms2),
      .busy  (busy2),
      .done  (done2),
      .y     (y2)
   );

   task automatic kick(input logic [1:0] d, input logic [47:0] t);
      @(negedge clk);
      depth = d;
      terms = t;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e0 = cyc;
   endtask

   // Returns edges since e0 at the done cycle, or -1 on timeout.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (done) begin
            lat = cyc - e0;
            return;
         end
      end
   endtask

   task automatic test_reset;
      #2;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
      total++; if (y !== 9'd0) begin bad++; $display("FAIL reset_y got=%0d want=0", y); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_perfect;
      int lat;
      kick(2'd3, {16'd4, 16'd2, 16'd2});
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL perfect_busy got=%0b want=1", busy); end
      wait_done(lat);
      total++; if (lat !== 30) begin bad++; $display("FAIL perfect_lat got=%0d want=30", lat); end
      total++; if (y !== 9'd2) begin bad++; $display("FAIL perfect_y got=%0d want=2", y); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL perfect_busy_done got=%0b want=0", busy); end
      kick(2'd3, {16'hFFFF, 16'hFFFF, 16'hFFFF});
      wait_done(lat);
      total++; if (y !== 9'd256) begin bad++; $display("FAIL max_y got=%0d want=256", y); end
   endtask

   task automatic test_nonperfect;
      int lat;
      kick(2'd3, {16'd15, 16'd1, 16'd7});
      wait_done(lat);
      total++; if (y !== 9'd3) begin bad++; $display("FAIL nonperfect_y got=%0d want=3", y); end
      kick(2'd3, 48'd0);
      wait_done(lat);
      total++; if (y !== 9'd0) begin bad++; $display("FAIL zero_y got=%0d want=0", y); end
   endtask

   task automatic test_depth;
      int lat;
      kick(2'd1, {16'd999, 16'd999, 16'd100});
      wait_done(lat);
      total++; if (lat !== 10) begin bad++; $display("FAIL depth1_lat got=%0d want=10", lat); end
      total++; if (y !== 9'd10) begin bad++; $display("FAIL depth1_y got=%0d want=10", y); end
      kick(2'd2, {16'd999, 16'd81, 16'd7});
      wait_done(lat);
      total++; if (lat !== 20) begin bad++; $display("FAIL depth2_lat got=%0d want=20", lat); end
      total++; if (y !== 9'd4) begin bad++; $display("FAIL depth2_y got=%0d want=4", y); end
   endtask

   task automatic test_clamp;
      int lat;
      kick(2'd0, {16'd500, 16'd300, 16'd49});
      wait_done(lat);
      total++; if (lat !== 10) begin bad++; $display("FAIL depth0_lat got=%0d want=10", lat); end
      total++; if (y !== 9'd7) begin bad++; $display("FAIL depth0_y got=%0d want=7", y); end
      @(negedge clk);
      depth2 = 2'd3;
      terms2 = {16'd81, 16'd7};
      start2 = 1'b1;
      @(posedge clk);
      #1;
      start2 = 1'b0;
      e0 = cyc;
      lat = -1;
      for (int n = 0; n < 200; n++) begin
         @(posedge clk);
         #1;
         if (done2) begin
            lat = cyc - e0;
            break;
         end
      end
      total++; if (lat !== 20) begin bad++; $display("FAIL clamp2_lat got=%0d want=20", lat); end
      total++; if (y2 !== 9'd4) begin bad++; $display("FAIL clamp2_y got=%0d want=4", y2); end
   endtask

   task automatic test_ignore_start;
      int lat;
      kick(2'd3, {16'd15, 16'd1, 16'd7});
      repeat (4) @(posedge clk);
      @(negedge clk);
      depth = 2'd1;
      terms = {16'd0, 16'd0, 16'd100};
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      terms = {16'hFFFF, 16'hFFFF, 16'hFFFF};
      depth = 2'd2;
      wait_done(lat);
      total++; if (lat !== 30) begin bad++; $display("FAIL ignore_lat got=%0d want=30", lat); end
      total++; if (y !== 9'd3) begin bad++; $display("FAIL ignore_y got=%0d want=3", y); end
   endtask

   task automatic test_start_on_done;
      int lat;
      kick(2'd2, {16'd0, 16'd81, 16'd7});
      wait_done(lat);
      total++; if (y !== 9'd4) begin bad++; $display("FAIL b2b_first_y got=%0d want=4", y); end
      depth = 2'd3;
      terms = {16'd4, 16'd2, 16'd2};
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      e0 = cyc;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%0b want=0", done); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%0b want=1", busy); end
      total++; if (y !== 9'd4) begin bad++; $display("FAIL b2b_hold_y got=%0d want=4", y); end
      wait_done(lat);
      total++; if (lat !== 30) begin bad++; $display("FAIL b2b_lat got=%0d want=30", lat); end
      total++; if (y !== 9'd2) begin bad++; $display("FAIL b2b_y got=%0d want=2", y); end
   endtask

   task automatic test_reset_mid;
      int lat;
      kick(2'd3, {16'd15, 16'd1, 16'd7});
      repeat (11) @(posedge clk);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_pre got=%0b want=1", busy); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done got=%0b want=0", done); end
      total++; if (y !== 9'd0) begin bad++; $display("FAIL mid_y got=%0d want=0", y); end
      @(negedge clk);
      rst = 1'b0;
      kick(2'd2, {16'd0, 16'd81, 16'd7});
      wait_done(lat);
      total++; if (lat !== 20) begin bad++; $display("FAIL mid_fresh_lat got=%0d want=20", lat); end
      total++; if (y !== 9'd4) begin bad++; $display("FAIL mid_fresh_y got=%0d want=4", y); end
   endtask

   initial begin
      test_reset;
      test_perfect;
      test_nonperfect;
      test_depth;
      test_clamp;
      test_ignore_start;
      test_start_on_done;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
